// File: rtl/spike_rate_monitor_if.sv
// Result channel of the spike rate monitor: {rate, isi} qualified by a valid/ready handshake.
interface spike_rate_monitor_if #(
   parameter int RATE_W = 8,
   parameter int ISI_W  = 12
);
   logic [RATE_W-1:0] rate;
   logic [ISI_W-1:0]  isi;
   logic              out_valid;
   logic              out_ready;

   modport master (output rate, output isi, output out_valid, input out_ready);
   modport slave  (input rate, input isi, input out_valid, output out_ready);
endinterface

// File: rtl/spike_rate_monitor.sv
// Counts spike onsets over a fixed window and tracks the latest inter-spike interval,
// delivering {rate, isi} per window through a one-entry result register.
module spike_rate_monitor #(
   parameter int WINDOW = 1000,
   parameter int RATE_W = 8,
   parameter int ISI_W  = 12
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       en,
   input  logic                       clr,
   input  logic                       spike,
   output logic                       overrun,
   spike_rate_monitor_if.master       res
);

   localparam int                 WCNT_W   = $clog2(WINDOW);
   localparam logic [WCNT_W-1:0]  W_LAST   = WCNT_W'(WINDOW - 1);
   localparam logic [RATE_W-1:0]  RATE_MAX = '1;
   localparam logic [ISI_W-1:0]   ISI_MAX  = '1;

   logic              spike_q;
   logic [WCNT_W-1:0] wcnt;
   logic [RATE_W-1:0] edge_cnt;
   logic [ISI_W-1:0]  isi_cnt;
   logic [ISI_W-1:0]  isi_last;
   logic              seen_first;

   logic              cnt_rise;
   logic              close;
   logic              accept;
   logic              load;
   logic [RATE_W-1:0] rate_next;
   logic [ISI_W-1:0]  isi_next;
   logic [ISI_W-1:0]  isi_cnt_next;

   always_comb begin
      cnt_rise  = en & spike & ~spike_q;
      close     = en && (wcnt == W_LAST);
      accept    = res.out_valid & res.out_ready;
      load      = close & (~res.out_valid | accept);
      // rate_next also serves as the saturated running count, so a close-cycle rise lands in the closing window
      rate_next = (edge_cnt == RATE_MAX) ? RATE_MAX : edge_cnt + RATE_W'(cnt_rise);
      isi_next  = (cnt_rise & seen_first) ? isi_cnt : isi_last;
      if (cnt_rise)
         isi_cnt_next = ISI_W'(1);
      else if (isi_cnt == ISI_MAX)
         isi_cnt_next = ISI_MAX;
      else
         isi_cnt_next = isi_cnt + ISI_W'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         spike_q       <= 1'b0;
         wcnt          <= '0;
         edge_cnt      <= '0;
         isi_cnt       <= '0;
         isi_last      <= '0;
         seen_first    <= 1'b0;
         overrun       <= 1'b0;
         res.rate      <= '0;
         res.isi       <= '0;
         res.out_valid <= 1'b0;
      end else begin
         spike_q <= spike;
         if (clr) begin
            wcnt          <= '0;
            edge_cnt      <= '0;
            isi_cnt       <= '0;
            isi_last      <= '0;
            seen_first    <= 1'b0;
            overrun       <= 1'b0;
            res.out_valid <= 1'b0;
         end else begin
            if (en) begin
               wcnt       <= close ? '0 : wcnt + WCNT_W'(1);
               edge_cnt   <= close ? '0 : rate_next;
               isi_cnt    <= isi_cnt_next;
               isi_last   <= isi_next;
               if (cnt_rise)
                  seen_first <= 1'b1;
            end
            // a pending result is never overwritten; a colliding close is dropped and flagged
            if (load) begin
               res.rate      <= rate_next;
               res.isi       <= isi_next;
               res.out_valid <= 1'b1;
            end else if (close) begin
               overrun <= 1'b1;
            end else if (accept) begin
               res.out_valid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_spike_rate_monitor.sv
// Directed bench: window/ISI behaviour on a 16-cycle monitor, saturation on 1024/8192-cycle monitors.
module tb_spike_rate_monitor;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic en_a = 1'b1, clr_a = 1'b0, spike_a = 1'b0, overrun_a;
   logic en_bc = 1'b1, clr_bc = 1'b0, spike_b = 1'b0, spike_c = 1'b0;
   logic overrun_b, overrun_c;
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   spike_rate_monitor_if ia ();
   spike_rate_monitor_if ib ();
   spike_rate_monitor_if ic ();

   spike_rate_monitor #(.WINDOW(16)) u_a (
      .clk(clk), .reset_n(reset_n), .en(en_a), .clr(clr_a), .spike(spike_a),
      .overrun(overrun_a), .res(ia));
   spike_rate_monitor #(.WINDOW(1024)) u_b (
      .clk(clk), .reset_n(reset_n), .en(en_bc), .clr(clr_bc), .spike(spike_b),
      .overrun(overrun_b), .res(ib));
   spike_rate_monitor #(.WINDOW(8192)) u_c (
      .clk(clk), .reset_n(reset_n), .en(en_bc), .clr(clr_bc), .spike(spike_c),
      .overrun(overrun_c), .res(ic));

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // leaves reset released #1 after an edge; the next edge is window cycle 0
   task automatic do_reset();
      reset_n = 1'b0;
      en_a = 1'b1; clr_a = 1'b0; spike_a = 1'b0; ia.out_ready = 1'b1;
      spike_b = 1'b0; spike_c = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   initial begin
      ia.out_ready = 1'b1;
      ib.out_ready = 1'b1;
      ic.out_ready = 1'b1;

      // reset state
      do_reset();
      check_val("rst_rate", 32'(ia.rate), 0);
      check_val("rst_valid", 32'(ia.out_valid), 0);
      check_val("rst_overrun", 32'(overrun_a), 0);

      // steady train: onsets every 4 cycles
      for (int k = 0; k <= 48; k++) begin
         spike_a = (k % 4 == 0);
         tick();
         if (k == 14) check_val("train_valid_early", 32'(ia.out_valid), 0);
         if (k == 15 || k == 31 || k == 47) begin
            check_val("train_valid", 32'(ia.out_valid), 1);
            check_val("train_rate", 32'(ia.rate), 4);
            check_val("train_isi", 32'(ia.isi), 4);
         end
         if (k == 32) check_val("train_valid_pulse", 32'(ia.out_valid), 0);
      end

      // long spike starting on the close cycle
      do_reset();
      for (int k = 0; k <= 31; k++) begin
         spike_a = (k >= 15 && k <= 19);
         tick();
         if (k == 15) begin
            check_val("long_valid", 32'(ia.out_valid), 1);
            check_val("long_rate1", 32'(ia.rate), 1);
            check_val("long_isi1", 32'(ia.isi), 0);
         end
         if (k == 31) begin
            check_val("long_rate2", 32'(ia.rate), 0);
            check_val("long_isi2", 32'(ia.isi), 0);
         end
      end

      // backpressure across three closes
      do_reset();
      ia.out_ready = 1'b0;
      for (int k = 0; k <= 47; k++) begin
         spike_a = (k == 3 || k == 20 || k == 22);
         tick();
         if (k == 15) begin
            check_val("bp_valid1", 32'(ia.out_valid), 1);
            check_val("bp_rate1", 32'(ia.rate), 1);
            check_val("bp_overrun1", 32'(overrun_a), 0);
         end
         if (k == 31) begin
            check_val("bp_rate2", 32'(ia.rate), 1);
            check_val("bp_isi2", 32'(ia.isi), 0);
            check_val("bp_overrun2", 32'(overrun_a), 1);
         end
         if (k == 47) begin
            check_val("bp_valid3", 32'(ia.out_valid), 1);
            check_val("bp_rate3", 32'(ia.rate), 1);
         end
      end
      ia.out_ready = 1'b1;
      tick();
      ia.out_ready = 1'b0;
      check_val("bp_accept_valid", 32'(ia.out_valid), 0);
      check_val("bp_accept_rate", 32'(ia.rate), 1);
      check_val("bp_overrun_sticky", 32'(overrun_a), 1);
      clr_a = 1'b1;
      tick();
      clr_a = 1'b0;
      check_val("bp_clr_overrun", 32'(overrun_a), 0);
      check_val("bp_clr_rate", 32'(ia.rate), 1);

      // enable gating: 10 frozen cycles with spike activity
      do_reset();
      for (int k = 0; k <= 26; k++) begin
         en_a = !(k >= 10 && k <= 19);
         spike_a = (k == 0 || k == 4 || k == 8 || k == 12 || k == 13 || k == 16 || k == 22);
         tick();
         if (k == 15) check_val("gate_no_early_close", 32'(ia.out_valid), 0);
         if (k == 24) check_val("gate_valid_before", 32'(ia.out_valid), 0);
         if (k == 25) begin
            check_val("gate_valid", 32'(ia.out_valid), 1);
            check_val("gate_rate", 32'(ia.rate), 4);
            check_val("gate_isi", 32'(ia.isi), 4);
         end
      end
      en_a = 1'b1;

      // asynchronous reset mid-window while holding a result
      do_reset();
      ia.out_ready = 1'b0;
      for (int k = 0; k <= 36; k++) begin
         spike_a = (k == 2 || k == 5);
         tick();
         if (k == 15) begin
            check_val("ar_valid", 32'(ia.out_valid), 1);
            check_val("ar_rate", 32'(ia.rate), 2);
            check_val("ar_isi", 32'(ia.isi), 3);
         end
         if (k == 31) check_val("ar_overrun", 32'(overrun_a), 1);
      end
      #2;
      reset_n = 1'b0;
      #1;
      check_val("ar_async_rate", 32'(ia.rate), 0);
      check_val("ar_async_isi", 32'(ia.isi), 0);
      check_val("ar_async_valid", 32'(ia.out_valid), 0);
      check_val("ar_async_overrun", 32'(overrun_a), 0);
      tick();
      reset_n = 1'b1;
      ia.out_ready = 1'b1;
      for (int k = 0; k <= 15; k++) begin
         tick();
         if (k == 14) check_val("ar_post_valid_early", 32'(ia.out_valid), 0);
         if (k == 15) begin
            check_val("ar_post_valid", 32'(ia.out_valid), 1);
            check_val("ar_post_rate", 32'(ia.rate), 0);
            check_val("ar_post_isi", 32'(ia.isi), 0);
         end
      end

      // saturation: rate on the 1024 window, isi on the 8192 window
      do_reset();
      for (int k = 0; k <= 8191; k++) begin
         spike_b = (k % 2 == 0);
         spike_c = (k == 100 || k == 5100);
         tick();
         if (k == 1023) begin
            check_val("sat_rate_valid", 32'(ib.out_valid), 1);
            check_val("sat_rate", 32'(ib.rate), 255);
            check_val("sat_rate_isi", 32'(ib.isi), 2);
         end
         if (k == 8191) begin
            check_val("sat_isi_valid", 32'(ic.out_valid), 1);
            check_val("sat_isi", 32'(ic.isi), 4095);
            check_val("sat_isi_rate", 32'(ic.rate), 2);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/spike_rate_monitor.md
# spike_rate_monitor

Downstream consumer of the Izhikevich neuron's `spike` output. Detects spike onsets and counts them over a fixed window of clock cycles. Measures the most recent inter-spike interval (ISI). Presents {rate, isi} results to the next stage through a valid/ready handshake with a one-entry holding register and a sticky overrun flag.

## Interface
Parameters:
- `WINDOW`, 1000: window length in clock cycles (≥ 2).
- `RATE_W`, 8: width of the rate result. Saturating.
- `ISI_W`, 12: width of the ISI result. Saturating.

Ports:
- `clk` in 1: the single clock; everything is on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `en` in 1: when high, the window and ISI counters run and spike onsets are counted.
- `clr` in 1: synchronous clear of measurement state and overrun.
- `spike` in 1: neuron spike level. May stay high for several cycles.
- `rate` out RATE_W: spike-onset count of the last delivered window.
- `isi` out ISI_W: last ISI in cycles at window close. 0 = fewer than two onsets seen.
- `out_valid` out 1: result register holds undelivered data.
- `out_ready` in 1: consumer accepts when `out_valid & out_ready`.
- `overrun` out 1: sticky flag; a window result was dropped.

## Operation
- Onset detect: `spike_q` is registered every cycle regardless of `en`. The onset signal is `rise = spike & ~spike_q`. A multi-cycle spike counts once.
- Onsets are counted only when `en`=1. When `en`=0, `wcnt`, `edge_cnt` and `isi_cnt` freeze. The handshake keeps operating.
- Window counter `wcnt` runs 0..WINDOW-1. The close event is `en` & `wcnt`==WINDOW-1. On close, `wcnt` goes to 0.
- `edge_cnt` increments on each counted `rise`, saturating at 2^RATE_W-1.
  - On close, the result rate is `sat(edge_cnt + rise)`.
  - `edge_cnt` then restarts at 0. A rise on the close cycle belongs to the closing window.
- ISI tracking:
  - `isi_cnt` increments each enabled cycle, saturating at 2^ISI_W-1.
  - On a counted rise, `isi_cnt` is set to 1.
  - On a counted rise with `seen_first`=1, `isi_last` takes the current `isi_cnt` value. For onsets at cycles t0 and t1, `isi_last` = t1−t0, saturated.
  - The first rise after reset or `clr` only sets `seen_first`.
- Result register, at close:
  - If `out_valid`=0, or `out_valid & out_ready` in the same cycle: load `rate` and `isi` (`isi` includes any update from a rise on this cycle) and set `out_valid`=1.
  - Otherwise: drop the new result, leave `rate`/`isi` unchanged, and set `overrun`=1.
- `out_valid & out_ready` with no close in the same cycle: `out_valid` goes to 0. `rate`/`isi` keep their values.
- `clr`=1 takes priority over everything except reset. It zeroes `wcnt`, `edge_cnt`, `isi_cnt`, `isi_last`, `seen_first`, `overrun` and `out_valid`. `rate`/`isi` keep their values. The `spike_q` update still occurs.

## Timing
- Reset (`reset_n`=0, asynchronous, takes effect immediately):
  - Outputs `rate`, `isi`, `out_valid` and `overrun` = 0.
  - Internal state: `wcnt`, `edge_cnt`, `isi_cnt`, `isi_last`, `seen_first` and `spike_q` = 0.
  - Reset mid-window discards the partial window.
- Release: the first enabled cycle after `reset_n` rises is window cycle 0. The first close is at the WINDOW-th enabled cycle.
- Latency: results appear and `out_valid` rises at the clock edge that ends the close cycle. They are visible in the following cycle.
- Throughput: one result per WINDOW enabled cycles. With `out_ready` held at 1, `out_valid` is a 1-cycle pulse per window.
- `out_valid` never drops without acceptance, `clr`, or reset. `rate`/`isi` are stable while `out_valid`=1.
- Spike input: `spike` is sampled at each rising edge of `clk`. A rise is registered one cycle after `spike` goes high, relative to the neuron's `v` update.

## Test plan
- Reset: assert `reset_n`=0 between clock edges mid-window with `out_valid`=1. Required: `rate`, `isi`, `out_valid` and `overrun` go to 0 immediately, without waiting for a clock edge. After release, the first result arrives WINDOW enabled cycles later.
- Steady train: WINDOW=16, `en`=1, `out_ready`=1, 1-cycle spikes every 4 cycles. Required from the second window on: `out_valid` pulses every 16 cycles with `rate`=4 and `isi`=4.
- Long spike plus close-cycle rise: WINDOW=16, `spike` held high for 5 cycles starting exactly at `wcnt`=15. Required: that window's `rate`=1, the next window's `rate`=0, and `isi`=0 (only one onset).
- Backpressure: WINDOW=16, `out_ready`=0 across three closes. Required: the first result is held unchanged and `overrun`=1 after the second close. Raising `out_ready` for one cycle clears `out_valid`. Pulsing `clr` clears `overrun`.
- Saturation: WINDOW=1024 with a spike every 2 cycles. Required: `rate`=255. Then two onsets 5000 cycles apart with WINDOW=8192. Required: `isi`=4095.
- Enable gating: `en`=0 for 10 cycles mid-window with spikes present. Required: no onsets counted, close delayed by exactly 10 cycles, and `isi` excludes the frozen cycles.
